// File: rtl/seq_lincomb_addsub.sv
`default_nettype none
// ============================================================================
// Module      : seq_lincomb_addsub
// Description : Multi-cycle linear combination R = ka*A +/- kb*B computed by
//               repeated add/subtract on one shared adder-subtractor. The
//               accumulator is wide enough to stay exact for all inputs.
//               Overflow into signed WIDTH is flagged with the result.
//               Build option LINCOMB_SATURATE_EN: an overflowed result
//               saturates by sign instead of wrapping modulo 2^WIDTH.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_lincomb_addsub #(
    parameter int WIDTH = 16,
    parameter int CW    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [CW-1:0]    ka,
    input  logic [CW-1:0]    kb,
    input  logic             sub_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    // Exact accumulator: |ka*A| + |kb*B| < 2^(WIDTH+CW), plus one sign bit.
    localparam int AW = WIDTH + CW + 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ADD_A  = 2'd1,
        S_STEP_B = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [WIDTH-1:0]      r_a;
    logic [WIDTH-1:0]      r_b;
    logic [CW-1:0]         r_cnt_a;
    logic [CW-1:0]         r_cnt_b;
    logic                  r_sub_b;
    logic signed [AW-1:0]  r_acc;

    logic                  w_accept;
    logic signed [AW-1:0]  w_a_ext;
    logic signed [AW-1:0]  w_b_ext;
    logic [AW-WIDTH:0]     w_top;
    logic                  w_ovf;
    logic [WIDTH-1:0]      w_res;

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_a_ext  = {{(AW-WIDTH){r_a[WIDTH-1]}}, r_a};
    assign w_b_ext  = {{(AW-WIDTH){r_b[WIDTH-1]}}, r_b};

    // Value fits in signed WIDTH only when the bits above the WIDTH-1 sign
    // position are all copies of it.
    assign w_top    = r_acc[AW-1:WIDTH-1];
    assign w_ovf    = !((&w_top) || !(|w_top));

`ifdef LINCOMB_SATURATE_EN
    // Saturate towards the accumulator sign on overflow.
    always_comb begin
        w_res = r_acc[WIDTH-1:0];
        if (w_ovf) begin
            if (r_acc[AW-1]) begin
                w_res = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                w_res = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
    end
`else
    // Modulo 2^WIDTH wrap of the exact value.
    always_comb begin
        w_res = r_acc[WIDTH-1:0];
    end
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; counters reaching 1 means this is the last step.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (ka != '0) begin
                        w_state_nxt = S_ADD_A;
                    end else if (kb != '0) begin
                        w_state_nxt = S_STEP_B;
                    end else begin
                        w_state_nxt = S_FINISH;
                    end
                end
            end
            S_ADD_A: begin
                if (r_cnt_a == CW'(1)) begin
                    w_state_nxt = (r_cnt_b != '0) ? S_STEP_B : S_FINISH;
                end
            end
            S_STEP_B: begin
                if (r_cnt_b == CW'(1)) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, iterative accumulate and result/handshake registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_sub_b <= 1'b0;
            r_acc   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_cnt_a <= ka;
                        r_cnt_b <= kb;
                        r_sub_b <= sub_b;
                        r_acc   <= '0;
                        busy    <= 1'b1;
                    end
                end
                S_ADD_A: begin
                    r_acc   <= r_acc + w_a_ext;
                    r_cnt_a <= r_cnt_a - CW'(1);
                end
                S_STEP_B: begin
                    r_acc   <= r_sub_b ? (r_acc - w_b_ext) : (r_acc + w_b_ext);
                    r_cnt_b <= r_cnt_b - CW'(1);
                end
                S_FINISH: begin
                    result <= w_res;
                    ovf    <= w_ovf;
                    done   <= 1'b1;
                    busy   <= 1'b0;
                end
                default: begin
                    busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_lincomb_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_lincomb_addsub
// Description : Self-checking bench for seq_lincomb_addsub (WIDTH=16, CW=4).
//               Table-driven vectors feed a scoreboard queue; a monitor pops
//               and compares on every done pulse. Hand sequences cover reset,
//               back-to-back start and mid-operation reset.
//               Honours LINCOMB_SATURATE_EN for expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_lincomb_addsub;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  ka;
    logic [3:0]  kb;
    logic        sub_b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  ka;
        logic [3:0]  kb;
        logic        sub_b;
        logic [15:0] res_wrap;
        logic [15:0] res_sat;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [15:0] res;
        logic        ovf;
    } exp_t;

    exp_t sbq[$];
    vec_t tbl[10];
    logic prev_done = 1'b0;

    seq_lincomb_addsub #(.WIDTH(16), .CW(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .ka     (ka),
        .kb     (kb),
        .sub_b  (sub_b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .ovf    (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic exp_t expect_of(input vec_t v);
        exp_t e;
`ifdef LINCOMB_SATURATE_EN
        e.res = v.res_sat;
`else
        e.res = v.res_wrap;
`endif
        e.ovf = v.ovf;
        return e;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 result=0x%0h expected no done", result);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("result", {16'd0, result}, {16'd0, e.res});
                    chk("ovf", {31'd0, ovf}, {31'd0, e.ovf});
                end
                chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
            end
            prev_done = done;
        end
    end

    task automatic drive(input vec_t v);
        a     = v.a;
        b     = v.b;
        ka    = v.ka;
        kb    = v.kb;
        sub_b = v.sub_b;
    endtask

    // Waits for done with a cycle budget; returns cycles counted after edge 0.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!done) chk("done_timeout", 32'd0, 32'd1);
    endtask

    // One operation from a table record; optionally scrambles inputs in flight.
    task automatic run_op(input vec_t v, input bit scramble);
        int n;
        drive(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        sbq.push_back(expect_of(v));
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        if (scramble) begin
            a     = 16'($urandom);
            b     = 16'($urandom);
            ka    = 4'($urandom);
            kb    = 4'($urandom);
            sub_b = 1'($urandom);
        end
        wait_done(n);
        if (done) begin
            chk("latency", n, 32'(v.ka) + 32'(v.kb) + 32'd1);
            chk("busy_at_done", {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        int n;
        vec_t v1;
        vec_t v2;
        //           a         b         ka     kb     sub   wrap      sat       ovf
        tbl[0] = '{16'd5,    16'd3,    4'd3,  4'd2,  1'b1, 16'd9,    16'd9,    1'b0};
        tbl[1] = '{16'hFFF9, 16'd4,    4'd1,  4'd3,  1'b0, 16'd5,    16'd5,    1'b0};
        tbl[2] = '{16'h1234, 16'h5678, 4'd0,  4'd0,  1'b0, 16'd0,    16'd0,    1'b0};
        tbl[3] = '{16'h4000, 16'hC000, 4'd2,  4'd1,  1'b1, 16'hC000, 16'h7FFF, 1'b1};
        tbl[4] = '{16'h8000, 16'h7FFF, 4'd15, 4'd15, 1'b1, 16'h000F, 16'h8000, 1'b1};
        tbl[5] = '{16'd100,  16'hFFCE, 4'd7,  4'd4,  1'b0, 16'h01F4, 16'h01F4, 1'b0};
        tbl[6] = '{16'hFC18, 16'hFC18, 4'd15, 4'd15, 1'b1, 16'h0000, 16'h0000, 1'b0};
        tbl[7] = '{16'h7FFF, 16'd1,    4'd1,  4'd1,  1'b0, 16'h8000, 16'h7FFF, 1'b1};
        tbl[8] = '{16'h8000, 16'd1,    4'd1,  4'd1,  1'b1, 16'h7FFF, 16'h8000, 1'b1};
        tbl[9] = '{16'h7FFF, 16'd0,    4'd1,  4'd0,  1'b0, 16'h7FFF, 16'h7FFF, 1'b0};

        rst_n = 1'b0;
        start = 1'b0;
        drive(tbl[0]);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", {16'd0, result}, 32'd0);
        chk("reset_ovf", {31'd0, ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Table vectors; odd entries scramble inputs during the operation.
        for (int i = 0; i < 10; i++) begin
            run_op(tbl[i], (i % 2) == 1);
            @(posedge clk);
            #1;
        end

        // start held high: second operation accepted in the done cycle.
        v1 = '{16'd10,   16'd3, 4'd2, 4'd2, 1'b0, 16'd26,   16'd26,   1'b0};
        v2 = '{16'hFFEC, 16'd7, 4'd2, 4'd2, 1'b1, 16'hFFCA, 16'hFFCA, 1'b0};
        drive(v1);
        start = 1'b1;
        @(posedge clk);
        #1;
        sbq.push_back(expect_of(v1));
        drive(v2);
        wait_done(n);
        if (done) chk("b2b_latency1", n, 32'd5);
        sbq.push_back(expect_of(v2));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy_second", {31'd0, busy}, 32'd1);
        wait_done(n);
        if (done) chk("b2b_latency2", n, 32'd5);
        @(posedge clk);
        #1;

        // Reset during ADD_A aborts with outputs cleared and no done.
        v1 = '{16'd5, 16'd3, 4'd5, 4'd2, 1'b0, 16'd31, 16'd31, 1'b0};
        drive(v1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_result", {16'd0, result}, 32'd0);
        chk("abort_ovf", {31'd0, ovf}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        run_op(tbl[0], 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", sbq.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seq_lincomb_addsub.md
Name: seq_lincomb_addsub

Overview:
- Parametrised, multi-cycle linear-combination unit. Computes R = ka*A ± kb*B by iterative add/subtract on one shared adder-subtractor datapath.
- Generalises the fixed 16-bit "3A-2B" chain to any width, runtime coefficients and add/sub mode, with a start/done handshake and overflow reporting.
- Sits between operand registers and result consumers in the lab datapath.

Parameters:
- WIDTH, 16, operand and result width in bits (two's complement).
- CW, 4, coefficient width in bits. ka and kb are unsigned, range 0..2^CW-1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request pulse. Sampled only in IDLE.
- a  input  WIDTH  signed operand A. Captured when start is accepted.
- b  input  WIDTH  signed operand B. Captured when start is accepted.
- ka  input  CW  coefficient of A. Captured when start is accepted.
- kb  input  CW  coefficient of B. Captured when start is accepted.
- sub_b  input  1  1: R = ka*A - kb*B; 0: R = ka*A + kb*B. Captured when start is accepted.
- busy  output  1  high from the edge after start is accepted until done.
- done  output  1  one-cycle pulse when result/ovf are valid.
- result  output  WIDTH  low WIDTH bits of R (or the saturated value, see Optional Feature). Held until the next done.
- ovf  output  1  R does not fit in signed WIDTH. Valid with done, held with result.

Behaviour:
- Reset: synchronous active-low on rst_n, single clock clk. When rst_n=0 at an edge: state=IDLE, busy=0, done=0, result=0, ovf=0, internal counters and accumulator cleared.
- Reset mid-operation aborts the computation: no done pulse, outputs zeroed.
- Internal accumulator is WIDTH+CW+1 bits, signed, and exact (no intermediate wrap). Operands are sign-extended into it.
- FSM states: IDLE, ADD_A, STEP_B, FINISH.
- IDLE: start=1 at edge 0 captures all inputs, clears the accumulator, loads cntA=ka and cntB=kb, and sets busy=1.
  - Next state: ADD_A if ka≠0; else STEP_B if kb≠0; else FINISH.
- ADD_A: each edge adds sign-extended A and decrements cntA. When cntA reaches 0, go to STEP_B (kb≠0) or FINISH.
- STEP_B: each edge adds B (sub_b=0) or subtracts B (sub_b=1), decrementing cntB. When cntB reaches 0, go to FINISH.
- FINISH: one edge loads result and ovf, pulses done=1, clears busy, returns to IDLE.
- Latency: done is high in the cycle after edge ka+kb+1, counted from the accepting edge 0. Minimum is 1 (ka=kb=0 gives result=0, ovf=0).
- start while busy=1 is ignored, with no queueing.
- start in the same cycle done is high is accepted, because the state is already IDLE.
- Back-to-back throughput is one operation per ka+kb+2 cycles.
- Input changes after the accepting edge have no effect on the operation in flight.
- ovf = 1 iff the accumulator is < -2^(WIDTH-1) or > 2^(WIDTH-1)-1 at FINISH.
- With ovf=1 and the feature off, result = accumulator[WIDTH-1:0] (modulo wrap).
- done is never high for more than one consecutive cycle.

Optional Feature:
- Macro: LINCOMB_SATURATE_EN.
- Defined: when ovf=1 at FINISH, result saturates by the accumulator sign.
  - Positive overflow → 2^(WIDTH-1)-1 (0x7FFF at WIDTH=16).
  - Negative overflow → -2^(WIDTH-1) (0x8000).
  - ovf is still asserted.
- Undefined: result is modulo 2^WIDTH as above. No saturation logic is synthesised.
- Timing and handshake are identical in both builds.

Test Plan:
- WIDTH=16, a=5, b=3, ka=3, kb=2, sub_b=1, start pulse → busy for 6 cycles, done pulse in the cycle after edge 6, result=9, ovf=0.
- a=-7 (0xFFF9), b=4, ka=1, kb=3, sub_b=0 → result=5, ovf=0. Then ka=0, kb=0 → done one cycle after start, result=0.
- a=0x4000, b=0xC000 (-16384), ka=2, kb=1, sub_b=1 → exact 49152.
  - Feature off: result=0xC000, ovf=1.
  - LINCOMB_SATURATE_EN: result=0x7FFF, ovf=1.
- a=0x8000, b=0x7FFF, ka=15, kb=15, sub_b=1 → ovf=1. Saturated build gives result=0x8000. Latency is 31 cycles to done.
- start held high continuously with ka=2, kb=2 → second operation accepted in the done cycle. Inputs changed mid-operation do not alter the in-flight result.
- rst_n=0 for one edge during ADD_A → no done pulse, all outputs 0. A following start completes normally with the correct result.
